// File: rtl/bcd_pkg.sv
// Shared definitions for the binary<->BCD conversion blocks.
package bcd_pkg;
  // Default sizing shared by both conversion directions.
  localparam int DECLEN_DEF = 9;
  localparam int BINLEN_DEF = 30;
  localparam int BCDW       = DECLEN_DEF * 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;
endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_dabble_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  // Values 5..9 map to 8..12; larger values never occur in a valid accumulator.
  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per cycle (shift-add-3).
// Results past the top digit are reduced modulo 10**DECLEN and flagged via ovf.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int DECLEN = DECLEN_DEF,
  parameter int BINLEN = BINLEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BINLEN-1:0]   BIN,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DECLEN*4-1:0] BCD,
  output logic                ovf,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam int ACCW = DECLEN * 4;
  localparam int CW   = $clog2(BINLEN + 1);

  bcd_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BINLEN-1:0] sh_q, sh_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACCW-1:0]   adj;

  // Per-digit +3 correction applied to the accumulator before each shift.
  for (genvar g = 0; g < DECLEN; g++) begin : g_dig
    bcd_dabble_digit u_dig (
      .d_i (acc_q[g*4 +: 4]),
      .d_o (adj[g*4 +: 4])
    );
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: accept in IDLE, BINLEN shifts, hold result in DONE until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          sh_d    = BIN;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // Bit shifted out of the top digit means the value exceeded 10**DECLEN.
        acc_d = {adj[ACCW-2:0], sh_q[BINLEN-1]};
        sh_d  = {sh_q[BINLEN-2:0], 1'b0};
        ovf_d = ovf_q | adj[ACCW-1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BINLEN - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign BCD       = acc_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed + random bench for bin2bcd_seq with a scoreboard of expected results.
module tb_bin2bcd_seq;
  localparam int DL = 9;
  localparam int BL = 30;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [BL-1:0]   BIN = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic [DL*4-1:0] BCD;
  logic            ovf;
  logic            out_valid;

  typedef struct packed {
    logic [DL*4-1:0] bcd;
    logic            ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  bin2bcd_seq #(.DECLEN(DL), .BINLEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BIN       (BIN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .BCD       (BCD),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: BIN mod 1e9 split into decimal digits, ovf when BIN >= 1e9.
  function automatic exp_t model(input longint unsigned b);
    exp_t e;
    longint unsigned v;
    v     = b % 64'd1000000000;
    e.ovf = (b >= 64'd1000000000);
    e.bcd = '0;
    for (int i = 0; i < DL; i++) begin
      e.bcd[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full conversion: accept, latency check, result check, optional stall, handoff.
  task automatic convert(input logic [BL-1:0] b, input int hold);
    exp_t e;
    int   w;
    int   lat;
    out_ready = (hold == 0);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    BIN      = b;
    in_valid = 1'b1;
    sb.push_back(model(64'(b)));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    BIN      = BL'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd30);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("bcd", 64'(BCD), 64'(e.bcd));
    check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      BIN      = BL'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_bcd", 64'(BCD), 64'(e.bcd));
      check("hold_ovf", {63'd0, ovf}, {63'd0, e.ovf});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", {63'd0, out_valid}, 64'd0);
    check("post_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_bcd", 64'(BCD), 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero, max in-range, overflow cases
    convert(30'd0, 0);
    convert(30'h3B9AC9FF, 0);
    convert(30'd1000000000, 0);
    convert(30'h3FFFFFFF, 0);

    // Consumer stalls for 5 cycles with stray in_valid pulses
    convert(30'd12345, 5);

    // Reset mid-conversion discards the operand
    BIN      = 30'd987654321;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_bcd", 64'(BCD), 64'd0);
    check("mid_rst_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    convert(30'd42, 0);

    // Random operands with random consumer stalls
    for (int i = 0; i < 12; i++) begin
      convert(BL'($urandom), int'($urandom_range(0, 3)));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
